ahblite_byte_loader: RTL and testbench
======================================

# ahblite_byte_loader

AHB-lite single-master write engine that packs an 8-bit valid/ready byte stream into 32-bit little-endian words and writes them to consecutive word addresses. It sits directly upstream of the AHB-lite block RAM slave and is used to preload program/data memory, for example from a UART or debug byte source. It drives a standard AHB-lite master port and tolerates wait states and ERROR responses from any slave on the bus.

## Interface
- `HPROT_VAL`, default 4'b0011: constant HPROT value (data, privileged, non-bufferable).
- `LEN_WIDTH`, default 16: width of the word-count input.

- `HCLK` in 1: clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `base_addr` in 32: first write address, sampled with `start`. Bits [1:0] are forced to 0.
- `word_len` in LEN_WIDTH: number of words to write, sampled with `start`.
- `s_valid` in 1: byte stream valid.
- `s_data` in 8: byte stream data.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `busy` out 1: high from the cycle after an accepted `start` until the end of the job.
- `done` out 1: one-cycle pulse at the end of the job.
- `error` out 1: set when the job is aborted by an ERROR response. Sticky until the next accepted `start`.
- `HADDR` out 32, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HPROT` out 4, `HMASTLOCK` out 1, `HWDATA` out 32: AHB-lite master outputs.
- `HREADY` in 1, `HRESP` in 1: AHB-lite bus ready and response.

## Operation
- **Reset values:** all outputs reset to
  - `HTRANS`=00, `HADDR`=0, `HWDATA`=0, `HWRITE`=0
  - `HSIZE`=3'b010, `HBURST`=000, `HPROT`=HPROT_VAL, `HMASTLOCK`=0
  - `s_ready`=0, `busy`=0, `done`=0, `error`=0
- **Constant outputs:** `HSIZE`, `HBURST`, `HPROT` and `HMASTLOCK` never change after reset.
- **FSM states:** IDLE, FILL, ADDR, DATA, FIN.
- **IDLE:**
  - On `start`: latch the address and length, clear `error`, clear the byte counter, then go to FILL.
  - If `word_len`=0, go to FIN instead. No bus transfer is issued.
- **FILL:**
  - `s_ready`=1.
  - Each accepted byte is written into lane `byte_cnt` of the word (first byte goes to [7:0], fourth to [31:24]), then `byte_cnt` increments modulo 4.
  - The fourth accepted byte moves the FSM to ADDR.
  - `s_ready`=0 in every other state.
- **ADDR:**
  - `HTRANS`=NONSEQ, `HWRITE`=1, `HADDR`=current address.
  - These are held unchanged while `HREADY`=0.
  - On `HREADY`=1, go to DATA.
- **DATA:**
  - `HTRANS`=IDLE, `HWRITE`=0.
  - `HWDATA`=assembled word, held while `HREADY`=0.
  - On `HREADY`=1 with `HRESP`=0: add 4 to the address, decrement the remaining count, then go to FILL, or to FIN if the count reaches 0.
  - The address wraps modulo 2^32.
- **ERROR response:** when `HRESP`=1 in DATA, on the first error cycle (`HREADY`=0):
  - set `error`
  - drive `HTRANS`=IDLE (it is already IDLE)
  - go to FIN.
  The remaining words are not written and no further bytes are accepted.
- **FIN:**
  - `done`=1 for one cycle, `busy`=0, then go to IDLE.
  - `error` stays valid alongside `done`.
- **`start` while not IDLE:** ignored.
- **Mid-job reset:** an `HRESETn` assertion returns everything to its reset values immediately. A partial word is discarded.

## Timing
- **Start:** `start` accepted at cycle T → `busy`=1 and `s_ready`=1 from T+1.
- **Per-word latency:** fourth byte accepted at cycle F → address phase at F+1, data phase at F+2 (no wait states). The next byte is accepted at F+3 at the earliest.
- **Throughput:** minimum 6 cycles per word. Address and data phases are never overlapped with the next address phase.
- **Job end:** last data phase completes at cycle D → `done` at D+1 and IDLE at D+2. `busy` is high through D and low from D+1.
- **Zero-length job:** `start` with `word_len`=0 at T → `done` at T+1 and no `HTRANS` activity.
- **Output registering:** `HADDR`, `HTRANS`, `HWRITE` and `HWDATA` are registered (FSM-decoded from registered state). `s_ready` decodes from the registered state only.

## Test plan
- **Basic write:** `base_addr`=0x100, `word_len`=2, bytes 01..08 with `HREADY` tied high → two NONSEQ writes, 0x100←0x04030201 and 0x104←0x08070605. `done` pulses once, `error`=0.
- **Wait states:** same job with `HREADY` low for 3 cycles in each address and data phase → `HADDR`, `HTRANS` and `HWDATA` stay stable through the stall. Memory contents are identical to the basic case.
- **Stream gaps:** `s_valid` toggles randomly → no byte is lost or duplicated. The writes occur only after the 4th byte of each word.
- **Error abort:** `word_len`=3, slave responds ERROR on word 2 → `error`=1 with `done`, word 3 is never addressed, `s_ready`=0 after the abort.
- **Edge cases:**
  - `word_len`=0 → `done` at T+1 with no transfers.
  - `base_addr`=0xFFFFFFFC with `word_len`=2 → second write goes to 0x00000000.
  - `start` pulsed mid-job → ignored.
- **Mid-job reset:** assert `HRESETn` after 2 bytes → all outputs return to reset values. The next job starts cleanly with a fresh byte lane 0.

Source files
------------

// File: rtl/ahblite_byte_loader.sv
// rtl/ahblite_byte_loader.sv - AHB-lite master that packs a byte stream into 32-bit words and writes them
//
// Packs an 8-bit valid/ready byte stream into little-endian 32-bit words and
// issues one single NONSEQ word write per packed word to consecutive word
// addresses. Address and data phases of a word never overlap the next word.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   start                 one-cycle job request, sampled only while idle
//   base_addr, word_len   job address (bits [1:0] ignored) and word count
//   s_valid/s_data/s_ready  byte stream, byte taken when s_valid & s_ready
//   busy, done, error     job status (error sticky until the next start)
//   HADDR..HWDATA         AHB-lite master outputs
//   HREADY, HRESP         AHB-lite transfer ready and response
module ahblite_byte_loader #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         LEN_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [LEN_WIDTH-1:0] word_len,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic                 HMASTLOCK,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ADDR,
    S_DATA,
    S_FIN
  } state_t;

  state_t               state;
  logic [31:0]          cur_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [1:0]           byte_cnt;
  logic [31:0]          word_buf;

  // Status outputs decode directly from the registered state.
  assign s_ready = (state == S_FILL);
  assign busy    = (state == S_FILL) || (state == S_ADDR) || (state == S_DATA);
  assign done    = (state == S_FIN);

  // Single-word, non-locked writes only.
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      cur_addr  <= 32'd0;
      remaining <= '0;
      byte_cnt  <= 2'd0;
      word_buf  <= 32'd0;
      error     <= 1'b0;
      HADDR     <= 32'd0;
      HTRANS    <= TRANS_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= {base_addr[31:2], 2'b00};
            remaining <= word_len;
            byte_cnt  <= 2'd0;
            error     <= 1'b0;
            state     <= (word_len == '0) ? S_FIN : S_FILL;
          end
        end

        S_FILL: begin
          if (s_valid) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte completes the word: the address phase is loaded
            // here so HADDR/HTRANS are already registered in ADDR.
            if (byte_cnt == 2'd3) begin
              state  <= S_ADDR;
              HTRANS <= TRANS_NONSEQ;
              HWRITE <= 1'b1;
              HADDR  <= cur_addr;
            end
          end
        end

        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= TRANS_IDLE;
            HWRITE <= 1'b0;
            HWDATA <= word_buf;
          end
        end

        S_DATA: begin
          // Abort on the first ERROR cycle; the two-cycle response tail is
          // absorbed while FIN reports the job end.
          if (HRESP) begin
            error  <= 1'b1;
            HTRANS <= TRANS_IDLE;
            state  <= S_FIN;
          end else if (HREADY) begin
            cur_addr  <= cur_addr + 32'd4;
            remaining <= remaining - LEN_WIDTH'(1);
            state     <= (remaining == LEN_WIDTH'(1)) ? S_FIN : S_FILL;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_byte_loader.sv
// tb/tb_ahblite_byte_loader.sv - randomized self-checking bench for ahblite_byte_loader
module tb_ahblite_byte_loader;

  localparam int LW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = 32'd0;
  logic [LW-1:0] word_len = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_ready, busy, done, error;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;

  ahblite_byte_loader #(.HPROT_VAL(4'b0011), .LEN_WIDTH(LW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .word_len(word_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .done(done), .error(error), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Job description, written by the stimulus process only.
  logic [7:0] byte_mem [0:255];
  int n_bytes   = 0;
  int job_id    = 0;
  int err_word  = -1;
  int wait_lo   = 0;
  int wait_hi   = 0;
  int valid_pct = 100;

  // Slave / byte-source observations, written by the bus process only.
  int          seen_job = 0;
  int          rd_ptr = 0;
  int          n_acc = 0;
  int          n_aph = 0;
  int          n_done = 0;
  int          n_wr = 0;
  int          last_end_cyc = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  bit          dp_pend = 0, aph_seen = 0, exp_ns = 0, d_seen = 0;
  int          dp_wait = 0, aw_wait = 0, err_stage = 0, wd = 0;
  logic [31:0] dp_addr = 0, a_addr = 0, d_first = 0;

  // Bus process: AHB slave with wait states / errors plus the byte source.
  // Everything is decided at the falling edge for the next rising edge.
  initial begin : bus
    forever begin
      @(negedge HCLK);
      if (job_id != seen_job) begin
        seen_job = job_id;
        rd_ptr = 0; n_acc = 0; n_aph = 0; n_done = 0; n_wr = 0; wd = 0;
      end
      if (!HRESETn) begin
        dp_pend = 0; aph_seen = 0; exp_ns = 0; d_seen = 0; err_stage = 0; wd = 0;
        HREADY = 1'b1; HRESP = 1'b0; s_valid = 1'b0;
        continue;
      end
      if (done) n_done++;
      if (exp_ns) begin
        chk("addr_phase_latency", HTRANS, 2'b10);
        exp_ns = 0;
      end
      if (dp_pend) begin
        if (!d_seen) begin
          d_first = HWDATA;
          d_seen  = 1;
        end else begin
          chk("hwdata_stable", HWDATA, d_first);
        end
        chk("htrans_idle_in_data", HTRANS, 2'b00);
        if (err_stage == 0 && n_wr == err_word) begin
          HREADY = 1'b0; HRESP = 1'b1; err_stage = 1; last_end_cyc = cyc;
        end else if (err_stage == 1) begin
          HREADY = 1'b1; HRESP = 1'b1; err_stage = 0; dp_pend = 0; d_seen = 0;
        end else if (dp_wait > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
          chk("busy_at_data_end", busy, 1);
          wr_addr[n_wr] = dp_addr;
          wr_data[n_wr] = HWDATA;
          n_wr++;
          last_end_cyc = cyc;
          dp_pend = 0; d_seen = 0;
        end
      end else if (HTRANS == 2'b10) begin
        chk("hwrite_in_addr", HWRITE, 1);
        if (!aph_seen) begin
          aph_seen = 1;
          a_addr   = HADDR;
          aw_wait  = int'($urandom_range(wait_hi, wait_lo));
        end else begin
          chk("haddr_stable", HADDR, a_addr);
        end
        if (aw_wait > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; aw_wait--;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
          n_aph++;
          dp_pend = 1; dp_addr = HADDR; aph_seen = 0;
          dp_wait = int'($urandom_range(wait_hi, wait_lo));
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
      if (rd_ptr < n_bytes && int'($urandom_range(99, 0)) < valid_pct) begin
        s_valid = 1'b1;
        s_data  = byte_mem[rd_ptr];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end
      if (s_valid && s_ready) begin
        rd_ptr++; n_acc++;
        if (wd == 3) begin
          wd = 0; exp_ns = 1;
        end else begin
          wd++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_bus"}, {HTRANS, HWRITE, HADDR}, 64'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_status"}, {s_ready, busy, done, error}, 4'b0000);
    chk({tag, "_const"}, {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
  endtask

  task automatic load_bytes(input int len, input bit seq);
    n_bytes = len * 4;
    for (int i = 0; i < len * 4; i++) byte_mem[i] = seq ? 8'(i + 1) : 8'($urandom);
  endtask

  task automatic run_job(input logic [31:0] base, input int len, input int errw, input int wlo,
                         input int whi, input int vpct, input bit poke, input bit seq);
    int          to;
    int          n_exp;
    bit          is_err;
    logic [31:0] a;
    logic [31:0] w;
    is_err    = (errw >= 0) && (errw < len);
    err_word  = errw;
    wait_lo   = wlo;
    wait_hi   = whi;
    valid_pct = vpct;
    load_bytes(len, seq);
    job_id++;
    start = 1'b1; base_addr = base; word_len = LW'(len);
    tick();
    start = 1'b0; base_addr = $urandom; word_len = LW'($urandom);
    chk("busy_after_start", busy, len != 0);
    chk("s_ready_after_start", s_ready, len != 0);
    if (len == 0) chk("done_zero_len_t1", done, 1);
    if (poke) begin
      tick(); tick();
      start = 1'b1; base_addr = 32'hDEAD_0000; word_len = LW'(7);
      tick();
      start = 1'b0;
    end
    to = 0;
    while (!done && to < 3000) begin
      tick();
      to++;
    end
    chk("done_timeout", to < 3000, 1);
    chk("busy_low_at_done", busy, 0);
    chk("error_with_done", error, is_err);
    if (len > 0) chk("done_latency", cyc, last_end_cyc + 1);
    tick();
    chk("done_one_pulse", done, 0);
    chk("s_ready_idle", s_ready, 0);
    chk("error_sticky", error, is_err);
    chk("const_outputs", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
    n_exp = is_err ? errw : len;
    chk("write_count", n_wr, n_exp);
    chk("addr_phase_count", n_aph, is_err ? errw + 1 : len);
    chk("done_count", n_done, 1);
    for (int i = 0; i < n_exp && i < n_wr; i++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      w = {byte_mem[4*i+3], byte_mem[4*i+2], byte_mem[4*i+1], byte_mem[4*i]};
      chk("wr_addr", wr_addr[i], a);
      chk("wr_data", wr_data[i], w);
    end
    if (is_err) begin
      tick(); tick(); tick();
      chk("no_bytes_after_abort", n_acc, 4 * (errw + 1));
      chk("s_ready_after_abort", s_ready, 0);
    end
  endtask

  task automatic reset_midjob();
    int to;
    err_word = -1; wait_lo = 0; wait_hi = 0; valid_pct = 60;
    load_bytes(2, 0);
    job_id++;
    start = 1'b1; base_addr = 32'h200; word_len = LW'(2);
    tick();
    start = 1'b0;
    to = 0;
    while (n_acc < 2 && to < 200) begin
      tick();
      to++;
    end
    chk("reset_wait_bytes", to < 200, 1);
    HRESETn = 1'b0;
    #1;
    chk_reset_values("midjob_reset");
    tick(); tick();
    HRESETn = 1'b1;
    tick();
    run_job(32'h300, 2, -1, 0, 1, 70, 0, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int len;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    chk_reset_values("reset");
    HRESETn = 1'b1;
    tick();
    run_job(32'h0000_0100, 2, -1, 0, 0, 100, 0, 1);   // basic: 0x100<-04030201, 0x104<-08070605
    run_job(32'h0000_0100, 2, -1, 3, 3, 100, 0, 1);   // 3 wait states per phase
    run_job(32'h0000_1000, 5, -1, 0, 2, 40, 0, 0);    // stream gaps
    run_job(32'h0000_2000, 3, 1, 0, 1, 80, 0, 0);     // ERROR on word 2
    run_job(32'h0000_0040, 0, -1, 0, 0, 100, 0, 0);   // zero length
    run_job(32'hFFFF_FFFC, 2, -1, 0, 1, 90, 0, 0);    // address wrap
    run_job(32'h0000_0503, 3, -1, 0, 2, 70, 1, 0);    // start mid-job, unaligned base
    reset_midjob();
    for (int k = 0; k < 8; k++) begin
      len = int'($urandom_range(4, 1));
      run_job($urandom, len, ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1,
              0, int'($urandom_range(3, 0)), int'($urandom_range(100, 30)), k[0], 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
